// File: rtl/regfile_read_arbiter_if.sv
// Bundle between the three operand requesters, the 16-entry register file and the read arbiter.
// The arbiter side uses the slave modport; the requester/regfile side uses master.
interface regfile_read_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int NREQ   = 3
);

  logic [NREQ-1:0]   req;
  logic [3:0]        addr0;
  logic [3:0]        addr1;
  logic [3:0]        addr2;
  logic              stall;
  logic [NREQ-1:0]   gnt;
  logic [3:0]        rf_sel;
  logic [DATA_W-1:0] rf_data;
  logic              wr_en;
  logic [3:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic [NREQ-1:0]   rvalid;

  modport master (
    output req, addr0, addr1, addr2, stall, rf_data, wr_en, wr_addr, wr_data,
    input  gnt, rf_sel, rdata0, rdata1, rdata2, rvalid
  );

  modport slave (
    input  req, addr0, addr1, addr2, stall, rf_data, wr_en, wr_addr, wr_data,
    output gnt, rf_sel, rdata0, rdata1, rdata2, rvalid
  );

endinterface

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one register-file read port among three operand requesters.
// Two stages: grant + rf_sel, then data return with write-to-read bypass.
module regfile_read_arbiter #(
  parameter int DATA_W = 32,
  parameter int NREQ   = 3
) (
  input logic                   clk,
  input logic                   rst_n,
  regfile_read_arbiter_if.slave bus
);

  logic [1:0]        rr_ptr;
  logic              s1_valid;
  logic [1:0]        s1_id;
  logic [NREQ-1:0]   gnt_q;
  logic [NREQ-1:0]   rvalid_q;
  logic [3:0]        rf_sel_q;
  logic [DATA_W-1:0] rdata_q [NREQ];

  logic [NREQ-1:0]   eligible;
  logic              grant_any;
  logic [1:0]        winner;
  logic [1:0]        cand;
  logic [3:0]        win_addr;
  logic [DATA_W-1:0] fwd;

  // Index k places after base, wrapping at three requesters.
  function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] k);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, k};
    if (sum >= 3'd3) sum = sum - 3'd3;
    return sum[1:0];
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [1:0] id);
    return NREQ'(1) << id;
  endfunction

  // Scan from the farthest candidate back to rr_ptr so the nearest eligible one wins.
  always_comb begin
    eligible  = bus.req & {NREQ{~bus.stall}};
    grant_any = 1'b0;
    winner    = 2'd0;
    cand      = 2'd0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = rr_idx(rr_ptr, 2'(k));
      if (eligible[cand]) begin
        grant_any = 1'b1;
        winner    = cand;
      end
    end
  end

  always_comb begin
    win_addr = bus.addr2;
    case (winner)
      2'd0:    win_addr = bus.addr0;
      2'd1:    win_addr = bus.addr1;
      default: win_addr = bus.addr2;
    endcase
  end

  // A write landing on the register being read this cycle must be seen by the reader.
  assign fwd = (bus.wr_en && (bus.wr_addr == rf_sel_q)) ? bus.wr_data : bus.rf_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= 2'd0;
      s1_valid <= 1'b0;
      s1_id    <= 2'd0;
      gnt_q    <= '0;
      rf_sel_q <= 4'd0;
    end else if (grant_any) begin
      rf_sel_q <= win_addr;
      s1_id    <= winner;
      s1_valid <= 1'b1;
      gnt_q    <= onehot(winner);
      rr_ptr   <= rr_idx(winner, 2'd1);
    end else begin
      gnt_q    <= '0;
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= '0;
      for (int i = 0; i < NREQ; i++) rdata_q[i] <= '0;
    end else begin
      rvalid_q <= s1_valid ? onehot(s1_id) : '0;
      if (s1_valid) rdata_q[s1_id] <= fwd;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rf_sel = rf_sel_q;
  assign bus.rdata0 = rdata_q[0];
  assign bus.rdata1 = rdata_q[1];
  assign bus.rdata2 = rdata_q[2];

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Bench for regfile_read_arbiter: directed scenarios plus randomized traffic
// against a cycle-level reference model of the arbitration and read return.
module tb_regfile_read_arbiter;

  localparam int DATA_W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  regfile_read_arbiter_if #(.DATA_W(DATA_W), .NREQ(3)) bus ();

  regfile_read_arbiter #(.DATA_W(DATA_W), .NREQ(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Register file contents, updated only by the stimulus process.
  logic [DATA_W-1:0] rf [16];
  assign bus.rf_data = rf[bus.rf_sel];

  int                m_ptr;
  bit                m_pend;
  int                m_pend_id;
  logic [3:0]        m_rfsel;
  logic [2:0]        m_gnt;
  logic [2:0]        m_rvalid;
  logic [DATA_W-1:0] m_rdata [3];

  task automatic model_reset();
    m_ptr = 0; m_pend = 0; m_pend_id = 0; m_rfsel = 4'd0;
    m_gnt = 3'b000; m_rvalid = 3'b000;
    for (int i = 0; i < 3; i++) m_rdata[i] = '0;
  endtask

  function automatic logic [3:0] addr_of(input int idx);
    if (idx == 0) return bus.addr0;
    if (idx == 1) return bus.addr1;
    return bus.addr2;
  endfunction

  task automatic drive(input logic [2:0] r, input logic [3:0] a0, input logic [3:0] a1,
                       input logic [3:0] a2, input logic s);
    bus.req = r; bus.addr0 = a0; bus.addr1 = a1; bus.addr2 = a2; bus.stall = s;
  endtask

  // Advance the reference one edge from the current inputs, then the DUT; returns at edge+1.
  task automatic tick();
    bit                found;
    int                w;
    logic              we;
    logic [3:0]        wa;
    logic [DATA_W-1:0] wd;
    found = 0; w = 0;
    if (!rst_n) begin
      model_reset();
    end else begin
      m_rvalid = 3'b000;
      if (m_pend) begin
        m_rvalid = 3'(1 << m_pend_id);
        m_rdata[m_pend_id] = (bus.wr_en && bus.wr_addr == m_rfsel) ? bus.wr_data : rf[m_rfsel];
      end
      if (!bus.stall)
        for (int k = 0; k < 3; k++)
          if (!found && bus.req[(m_ptr + k) % 3]) begin
            found = 1;
            w = (m_ptr + k) % 3;
          end
      if (found) begin
        m_gnt = 3'(1 << w); m_pend = 1; m_pend_id = w;
        m_rfsel = addr_of(w); m_ptr = (w + 1) % 3;
      end else begin
        m_gnt = 3'b000; m_pend = 0;
      end
    end
    we = bus.wr_en; wa = bus.wr_addr; wd = bus.wr_data;
    @(posedge clk);
    #1;
    if (we) rf[wa] = wd;
  endtask

  task automatic test_reset();
    drive(3'b000, 4'd0, 4'd0, 4'd0, 1'b0);
    bus.wr_en = 1'b0; bus.wr_addr = 4'd0; bus.wr_data = '0;
    for (int i = 0; i < 16; i++) rf[i] = $urandom;
    model_reset();
    rst_n = 1'b0;
    #2;
    checks++; if (bus.gnt !== 3'b000) begin errors++; $display("[TB] FAIL reset_gnt: got %b expected 000", bus.gnt); end
    checks++; if (bus.rvalid !== 3'b000) begin errors++; $display("[TB] FAIL reset_rvalid: got %b expected 000", bus.rvalid); end
    checks++; if (bus.rf_sel !== 4'd0) begin errors++; $display("[TB] FAIL reset_rf_sel: got %0d expected 0", bus.rf_sel); end
    checks++; if ({bus.rdata0, bus.rdata1, bus.rdata2} !== '0) begin errors++; $display("[TB] FAIL reset_rdata: got %h %h %h expected zeros", bus.rdata0, bus.rdata1, bus.rdata2); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    rf[5] = 32'hDEADBEEF;
    drive(3'b001, 4'd5, 4'd0, 4'd0, 1'b0);
    tick();
    checks++; if (bus.gnt !== 3'b001) begin errors++; $display("[TB] FAIL single_gnt: got %b expected 001", bus.gnt); end
    checks++; if (bus.rf_sel !== 4'd5) begin errors++; $display("[TB] FAIL single_rf_sel: got %0d expected 5", bus.rf_sel); end
    checks++; if (bus.rvalid !== 3'b000) begin errors++; $display("[TB] FAIL single_rvalid_early: got %b expected 000", bus.rvalid); end
    drive(3'b000, 4'd5, 4'd0, 4'd0, 1'b0);
    tick();
    checks++; if (bus.rvalid !== 3'b001) begin errors++; $display("[TB] FAIL single_rvalid: got %b expected 001", bus.rvalid); end
    checks++; if (bus.rdata0 !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL single_rdata0: got %h expected deadbeef", bus.rdata0); end
    checks++; if (bus.gnt !== 3'b000) begin errors++; $display("[TB] FAIL single_gnt_drop: got %b expected 000", bus.gnt); end
  endtask

  task automatic test_contention();
    logic [2:0] exp_g;
    logic [2:0] exp_v;
    rst_n = 1'b0; #1; rst_n = 1'b1;
    model_reset();
    drive(3'b111, 4'd1, 4'd2, 4'd3, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_g = 3'(1 << (i % 3));
      exp_v = (i == 0) ? 3'b000 : 3'(1 << ((i - 1) % 3));
      checks++; if (bus.gnt !== exp_g) begin errors++; $display("[TB] FAIL contention_gnt[%0d]: got %b expected %b", i, bus.gnt, exp_g); end
      checks++; if (bus.rvalid !== exp_v) begin errors++; $display("[TB] FAIL contention_rvalid[%0d]: got %b expected %b", i, bus.rvalid, exp_v); end
    end
    drive(3'b000, 4'd0, 4'd0, 4'd0, 1'b0);
    tick();
    checks++; if (bus.rvalid !== 3'b100) begin errors++; $display("[TB] FAIL contention_rvalid_last: got %b expected 100", bus.rvalid); end
    checks++; if (bus.rdata2 !== rf[3]) begin errors++; $display("[TB] FAIL contention_rdata2: got %h expected %h", bus.rdata2, rf[3]); end
  endtask

  task automatic test_bypass();
    rf[3] = 32'hAAAA5555;
    drive(3'b010, 4'd0, 4'd3, 4'd0, 1'b0);
    tick();
    checks++; if (bus.gnt !== 3'b010) begin errors++; $display("[TB] FAIL bypass_gnt: got %b expected 010", bus.gnt); end
    drive(3'b000, 4'd0, 4'd3, 4'd0, 1'b0);
    bus.wr_en = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 32'h12345678;
    tick();
    bus.wr_en = 1'b0;
    checks++; if (bus.rdata1 !== 32'h12345678) begin errors++; $display("[TB] FAIL bypass_hit_rdata1: got %h expected 12345678", bus.rdata1); end
    rf[7] = 32'h0BADF00D;
    drive(3'b010, 4'd0, 4'd7, 4'd0, 1'b0);
    tick();
    drive(3'b000, 4'd0, 4'd7, 4'd0, 1'b0);
    bus.wr_en = 1'b1; bus.wr_addr = 4'd8; bus.wr_data = 32'hFFFF0000;
    tick();
    bus.wr_en = 1'b0;
    checks++; if (bus.rdata1 !== 32'h0BADF00D) begin errors++; $display("[TB] FAIL bypass_miss_rdata1: got %h expected 0badf00d", bus.rdata1); end
  endtask

  task automatic test_stall();
    drive(3'b001, 4'd9, 4'd2, 4'd0, 1'b0);
    tick();
    checks++; if (bus.gnt !== 3'b001) begin errors++; $display("[TB] FAIL stall_pre_gnt: got %b expected 001", bus.gnt); end
    drive(3'b010, 4'd9, 4'd2, 4'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.gnt !== 3'b000) begin errors++; $display("[TB] FAIL stall_gnt[%0d]: got %b expected 000", i, bus.gnt); end
      checks++; if (bus.rvalid !== ((i == 0) ? 3'b001 : 3'b000)) begin errors++; $display("[TB] FAIL stall_rvalid[%0d]: got %b", i, bus.rvalid); end
    end
    checks++; if (bus.rdata0 !== rf[9]) begin errors++; $display("[TB] FAIL stall_rdata0: got %h expected %h", bus.rdata0, rf[9]); end
    drive(3'b010, 4'd9, 4'd2, 4'd0, 1'b0);
    tick();
    checks++; if (bus.gnt !== 3'b010) begin errors++; $display("[TB] FAIL stall_release_gnt: got %b expected 010", bus.gnt); end
    drive(3'b000, 4'd0, 4'd0, 4'd0, 1'b0);
    tick();
    checks++; if (bus.rdata1 !== rf[2]) begin errors++; $display("[TB] FAIL stall_release_rdata1: got %h expected %h", bus.rdata1, rf[2]); end
  endtask

  task automatic test_reset_midflight();
    drive(3'b001, 4'd4, 4'd0, 4'd0, 1'b0);
    tick();
    checks++; if (bus.gnt !== 3'b001) begin errors++; $display("[TB] FAIL midflight_gnt: got %b expected 001", bus.gnt); end
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.gnt, bus.rvalid, bus.rf_sel} !== 10'd0) begin errors++; $display("[TB] FAIL midflight_async_clear: got gnt=%b rvalid=%b rf_sel=%0d expected all 0", bus.gnt, bus.rvalid, bus.rf_sel); end
    checks++; if ({bus.rdata0, bus.rdata1, bus.rdata2} !== '0) begin errors++; $display("[TB] FAIL midflight_rdata_clear: got %h %h %h expected zeros", bus.rdata0, bus.rdata1, bus.rdata2); end
    drive(3'b000, 4'd0, 4'd0, 4'd0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (bus.rvalid !== 3'b000) begin errors++; $display("[TB] FAIL midflight_no_rvalid: got %b expected 000", bus.rvalid); end
    drive(3'b111, 4'd1, 4'd2, 4'd3, 1'b0);
    tick();
    checks++; if (bus.gnt !== 3'b001) begin errors++; $display("[TB] FAIL midflight_restart_gnt: got %b expected 001", bus.gnt); end
    drive(3'b000, 4'd0, 4'd0, 4'd0, 1'b0);
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(3'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0));
      bus.wr_en   = 1'($urandom);
      bus.wr_addr = ($urandom_range(0, 1) == 0) ? bus.rf_sel : 4'($urandom);
      bus.wr_data = $urandom;
      tick();
      checks++; if (bus.gnt !== m_gnt) begin errors++; $display("[TB] FAIL rand_gnt[%0d]: got %b expected %b", n, bus.gnt, m_gnt); end
      checks++; if (bus.rvalid !== m_rvalid) begin errors++; $display("[TB] FAIL rand_rvalid[%0d]: got %b expected %b", n, bus.rvalid, m_rvalid); end
      checks++; if (bus.rf_sel !== m_rfsel) begin errors++; $display("[TB] FAIL rand_rf_sel[%0d]: got %0d expected %0d", n, bus.rf_sel, m_rfsel); end
      checks++; if (bus.rdata0 !== m_rdata[0]) begin errors++; $display("[TB] FAIL rand_rdata0[%0d]: got %h expected %h", n, bus.rdata0, m_rdata[0]); end
      checks++; if (bus.rdata1 !== m_rdata[1]) begin errors++; $display("[TB] FAIL rand_rdata1[%0d]: got %h expected %h", n, bus.rdata1, m_rdata[1]); end
      checks++; if (bus.rdata2 !== m_rdata[2]) begin errors++; $display("[TB] FAIL rand_rdata2[%0d]: got %h expected %h", n, bus.rdata2, m_rdata[2]); end
      checks++; if (!$onehot0(bus.gnt) || !$onehot0(bus.rvalid)) begin errors++; $display("[TB] FAIL rand_onehot[%0d]: got gnt=%b rvalid=%b expected one-hot or zero", n, bus.gnt, bus.rvalid); end
    end
    bus.wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] regfile_read_arbiter bench start");
    test_reset();
    test_single_read();
    test_contention();
    test_bypass();
    test_stall();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
